// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder controller.
// The slave side is the controller; the master side is the operand source plus result sink.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit ripple slice reused once per clock.
// The carry lives in a register between nibble passes; result is handed off via valid/ready.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_add_ctrl_if.slave bus_io
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_co;
  logic             last_pass;

  // Select the operand nibbles for the current pass.
  assign slice_a   = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b   = b_q[{idx_q, 2'b00} +: 4];
  assign last_pass = (idx_q == IW'(NIB - 1));

  // Shared 4-bit ripple-carry slice fed by the carry register.
  always_comb begin
    logic c;
    c       = carry_q;
    slice_s = '0;
    for (int i = 0; i < 4; i++) begin
      slice_s[i] = slice_a[i] ^ slice_b[i] ^ c;
      c          = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
    end
    slice_co = c;
  end

  // Sequencing: accept operands, one nibble per clock, hold result until taken.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.a;
          // Subtraction as a + ~b + 1; cin is ignored in that mode.
          b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
          carry_d = bus_io.sub ? 1'b1 : bus_io.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d                    = slice_co;
        idx_d                      = idx_q + IW'(1);
        if (last_pass) begin
          // Final carry and signed overflow are captured as the top nibble lands.
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_s[3] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed vector table and corner sequences at WIDTH=16,
// plus random traffic at WIDTH=8 and WIDTH=32 checked against an arithmetic model.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_aux = 1'b1;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) if16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(8))  if8 ();
  nibble_serial_add_ctrl_if #(.WIDTH(32)) if32 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst),     .bus_io(if16));
  nibble_serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst_aux), .bus_io(if8));
  nibble_serial_add_ctrl #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst_aux), .bus_io(if32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        tbl [8];
  logic [65:0] sb16 [$];
  logic [65:0] sb8  [$];
  logic [65:0] sb32 [$];
  int          nvec  = 0;
  int          nfail = 0;
  bit          done8 = 1'b0;
  bit          done32 = 1'b0;

  // Reference result packed as {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, bb, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = sub ? (~b & mask) : b;
    full = {1'b0, a} + {1'b0, bb} + {64'b0, (sub ? 1'b1 : cin)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    nfail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [65:0] out16();
    return {if16.ovf, if16.cout, 48'b0, if16.sum};
  endfunction

  // Wait for in_ready, present operands for one accepting edge, record the expectation.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [65:0] exp, output int waited);
    waited = 0;
    while (!if16.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!if16.in_ready) fail_now("send16_ready");
    if16.a        = a;
    if16.b        = b;
    if16.cin      = cin;
    if16.sub      = sub;
    if16.in_valid = 1'b1;
    sb16.push_back(exp);
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  // Count negedges from just after the accepting edge until out_valid, then score.
  task automatic recv16(input string name, output int lat);
    lat = 0;
    while (!if16.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!if16.out_valid) fail_now(name);
    else if (sb16.size() == 0) fail_now({name, "_empty_sb"});
    else chk(name, out16(), sb16.pop_front());
  endtask

  initial begin : rel_aux
    repeat (2) @(negedge clk);
    rst_aux = 1'b0;
  end

  // Directed WIDTH=16 sequences.
  initial begin : main_blk
    int w, lat, t;
    logic [65:0] e;
    logic [15:0] ra, rb;
    logic        rc, rs;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    // Operands offered while reset is held must not start a transaction.
    if16.in_valid  = 1'b1;
    if16.a         = 16'hFFFF;
    if16.b         = 16'hFFFF;
    if16.cin       = 1'b1;
    if16.sub       = 1'b0;
    if16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_sum", 66'(if16.sum), 66'd0);
    chk("reset_flags", {62'b0, if16.in_ready, if16.out_valid, if16.cout, if16.ovf},
        {62'b0, 4'b1000});
    rst           = 1'b0;
    if16.in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {64'b0, if16.in_ready, if16.out_valid}, {64'b0, 2'b10});

    // Table vectors; every transaction after the first should see a one-cycle bubble.
    for (int i = 0; i < 8; i++) begin
      send16(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
             {tbl[i].ovf, tbl[i].cout, 48'b0, tbl[i].sum}, w);
      if (i > 0) chk($sformatf("bubble%0d", i), 66'(w), 66'd1);
      recv16($sformatf("vec%0d", i), lat);
      chk($sformatf("latency%0d", i), 66'(lat), 66'd4);
    end

    // Backpressure with a foreign in_valid pulse during RUN and DONE.
    @(negedge clk);
    if16.out_ready = 1'b0;
    e = {1'b1, 1'b0, 48'b0, 16'h8000};
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, e, w);
    if16.a        = 16'hAAAA;
    if16.b        = 16'h5555;
    if16.in_valid = 1'b1;
    recv16("bp_result", lat);
    chk("bp_latency", 66'(lat), 66'd4);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", out16(), e);
      chk("bp_handshake", {64'b0, if16.in_ready, if16.out_valid}, {64'b0, 2'b01});
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {64'b0, if16.in_ready, if16.out_valid}, {64'b0, 2'b10});
    @(negedge clk);
    chk("bp_no_ghost", {64'b0, if16.in_ready, if16.out_valid}, {64'b0, 2'b10});

    // Reset after two RUN passes aborts the transaction.
    send16(16'h1234, 16'h4321, 1'b0, 1'b0, {2'b00, 48'b0, 16'h5555}, w);
    @(negedge clk);
    @(negedge clk);
    chk("mid_partial_sum", 66'(if16.sum), 66'h0055);
    rst = 1'b1;
    #1;
    chk("rst_sum", 66'(if16.sum), 66'd0);
    chk("rst_flags", {62'b0, if16.in_ready, if16.out_valid, if16.cout, if16.ovf},
        {62'b0, 4'b1000});
    sb16.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_valid", {64'b0, if16.in_ready, if16.out_valid}, {64'b0, 2'b10});
    end
    send16(16'h00FF, 16'h0001, 1'b0, 1'b0, {2'b00, 48'b0, 16'h0100}, w);
    recv16("after_rst", lat);
    chk("after_rst_latency", 66'(lat), 66'd4);

    // Random WIDTH=16 traffic.
    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send16(ra, rb, rc, rs, model(16, {48'b0, ra}, {48'b0, rb}, rc, rs), w);
      recv16("rnd16", lat);
    end

    t = 0;
    while (!(done8 && done32) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(done8 && done32)) fail_now("random_streams");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Random WIDTH=8 traffic with random result backpressure.
  initial begin : rnd8_blk
    int n;
    logic [7:0] a, b;
    logic ci, su;
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    if8.a         = '0;
    if8.b         = '0;
    if8.cin       = 1'b0;
    if8.sub       = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2000; k++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      su = 1'($urandom);
      n  = 0;
      while (!if8.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if8.a        = a;
      if8.b        = b;
      if8.cin      = ci;
      if8.sub      = su;
      if8.in_valid = 1'b1;
      sb8.push_back(model(8, {56'b0, a}, {56'b0, b}, ci, su));
      @(negedge clk);
      if8.in_valid = 1'b0;
      n = 0;
      while (!if8.out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!if8.out_valid) begin
        fail_now("rnd8");
        sb8.delete();
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("rnd8", {if8.ovf, if8.cout, 56'b0, if8.sum}, sb8.pop_front());
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
      end
    end
    done8 = 1'b1;
  end

  // Random WIDTH=32 traffic with random result backpressure.
  initial begin : rnd32_blk
    int n;
    logic [31:0] a, b;
    logic ci, su;
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b0;
    if32.a         = '0;
    if32.b         = '0;
    if32.cin       = 1'b0;
    if32.sub       = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2000; k++) begin
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom);
      su = 1'($urandom);
      n  = 0;
      while (!if32.in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if32.a        = a;
      if32.b        = b;
      if32.cin      = ci;
      if32.sub      = su;
      if32.in_valid = 1'b1;
      sb32.push_back(model(32, {32'b0, a}, {32'b0, b}, ci, su));
      @(negedge clk);
      if32.in_valid = 1'b0;
      n = 0;
      while (!if32.out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!if32.out_valid) begin
        fail_now("rnd32");
        sb32.delete();
      end else begin
        chk("rnd32_latency", 66'(n), 66'd8);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("rnd32", {if32.ovf, if32.cout, 32'b0, if32.sum}, sb32.pop_front());
        if32.out_ready = 1'b1;
        @(negedge clk);
        if32.out_ready = 1'b0;
      end
    end
    done32 = 1'b1;
  end

endmodule
